// File: rtl/nanorv32_lsu.sv
// rtl/nanorv32_lsu.sv - nanorv32 load/store unit between execute stage and data memory
// One outstanding access; misaligned requests and memory timeouts are reported as pulses.

module nanorv32_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_req_valid,
  input  logic        exe_req_write,
  input  logic [1:0]  exe_req_size,
  input  logic        exe_req_unsigned,
  input  logic [31:0] exe_req_addr,
  input  logic [31:0] exe_req_wdata,
  input  logic [4:0]  exe_req_rd,
  output logic        lsu_stall,
  output logic        lsu_wb_valid,
  output logic [4:0]  lsu_wb_rd,
  output logic [31:0] lsu_wb_data,
  output logic        lsu_misaligned,
  output logic        lsu_timeout,
  output logic [31:0] cpu_datamem_addr,
  output logic [31:0] cpu_datamem_wdata,
  output logic [3:0]  cpu_datamem_bytesel,
  output logic        cpu_datamem_write,
  output logic        cpu_datamem_req,
  input  logic [31:0] datamem_cpu_rdata,
  input  logic        datamem_cpu_ack
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bytesel_q, bytesel_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  off_q, off_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misaligned_q, misaligned_d;
  logic        timeout_q, timeout_d;

  logic        req_aligned;
  logic [31:0] req_wdata;
  logic [3:0]  req_bytesel;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic        tmo_hit;

  always_comb begin
    req_aligned = 1'b0;
    req_wdata   = exe_req_wdata;
    req_bytesel = 4'b1111;
    case (exe_req_size)
      2'b00: begin
        req_aligned = 1'b1;
        req_wdata   = {4{exe_req_wdata[7:0]}};
        case (exe_req_addr[1:0])
          2'd0:    req_bytesel = 4'b0001;
          2'd1:    req_bytesel = 4'b0010;
          2'd2:    req_bytesel = 4'b0100;
          default: req_bytesel = 4'b1000;
        endcase
      end
      2'b01: begin
        req_aligned = ~exe_req_addr[0];
        req_wdata   = {2{exe_req_wdata[15:0]}};
        req_bytesel = exe_req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        req_aligned = (exe_req_addr[1:0] == 2'b00);
      end
      default: begin
        req_aligned = 1'b0;
      end
    endcase
  end

  // Lane select and extension use the offset captured at accept, not the live address.
  always_comb begin
    load_byte = datamem_cpu_rdata[7:0];
    case (off_q)
      2'd0:    load_byte = datamem_cpu_rdata[7:0];
      2'd1:    load_byte = datamem_cpu_rdata[15:8];
      2'd2:    load_byte = datamem_cpu_rdata[23:16];
      default: load_byte = datamem_cpu_rdata[31:24];
    endcase
    load_half = off_q[1] ? datamem_cpu_rdata[31:16] : datamem_cpu_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{load_byte[7] & ~unsigned_q}}, load_byte};
      2'b01:   load_ext = {{16{load_half[15] & ~unsigned_q}}, load_half};
      default: load_ext = datamem_cpu_rdata;
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bytesel_d    = bytesel_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    rd_d         = rd_q;
    off_d        = off_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q marks the retiring request still on the execute port; ignore it once.
        if (exe_req_valid && !done_q) begin
          if (req_aligned) begin
            state_d    = ST_WAIT;
            req_d      = 1'b1;
            cnt_d      = 16'd0;
            addr_d     = {exe_req_addr[31:2], 2'b00};
            wdata_d    = req_wdata;
            bytesel_d  = req_bytesel;
            write_d    = exe_req_write;
            size_d     = exe_req_size;
            unsigned_d = exe_req_unsigned;
            rd_d       = exe_req_rd;
            off_d      = exe_req_addr[1:0];
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (datamem_cpu_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!write_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_ext;
          end
        end else if (tmo_hit) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      cnt_q        <= 16'd0;
      req_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      bytesel_q    <= 4'd0;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      rd_q         <= 5'd0;
      off_q        <= 2'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      bytesel_q    <= bytesel_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      rd_q         <= rd_d;
      off_q        <= off_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  // Gated by rst_n so the stall also drops the instant reset is applied.
  assign lsu_stall = rst_n & (((state_q == ST_IDLE) & exe_req_valid & req_aligned & ~done_q)
                              | (state_q == ST_WAIT));

  assign lsu_wb_valid        = wb_valid_q;
  assign lsu_wb_rd           = wb_rd_q;
  assign lsu_wb_data         = wb_data_q;
  assign lsu_misaligned      = misaligned_q;
  assign lsu_timeout         = timeout_q;
  assign cpu_datamem_addr    = addr_q;
  assign cpu_datamem_wdata   = wdata_q;
  assign cpu_datamem_bytesel = bytesel_q;
  assign cpu_datamem_write   = write_q;
  assign cpu_datamem_req     = req_q;

endmodule

// File: tb/tb_nanorv32_lsu.sv
// tb/tb_nanorv32_lsu.sv - randomized self-checking bench for nanorv32_lsu
// Expected values come from arithmetic on the access rules, checked cycle by cycle.

module tb_nanorv32_lsu;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_req_valid;
  logic        exe_req_write;
  logic [1:0]  exe_req_size;
  logic        exe_req_unsigned;
  logic [31:0] exe_req_addr;
  logic [31:0] exe_req_wdata;
  logic [4:0]  exe_req_rd;
  logic        lsu_stall;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        lsu_misaligned;
  logic        lsu_timeout;
  logic [31:0] cpu_datamem_addr;
  logic [31:0] cpu_datamem_wdata;
  logic [3:0]  cpu_datamem_bytesel;
  logic        cpu_datamem_write;
  logic        cpu_datamem_req;
  logic [31:0] datamem_cpu_rdata;
  logic        datamem_cpu_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nanorv32_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .exe_req_valid      (exe_req_valid),
    .exe_req_write      (exe_req_write),
    .exe_req_size       (exe_req_size),
    .exe_req_unsigned   (exe_req_unsigned),
    .exe_req_addr       (exe_req_addr),
    .exe_req_wdata      (exe_req_wdata),
    .exe_req_rd         (exe_req_rd),
    .lsu_stall          (lsu_stall),
    .lsu_wb_valid       (lsu_wb_valid),
    .lsu_wb_rd          (lsu_wb_rd),
    .lsu_wb_data        (lsu_wb_data),
    .lsu_misaligned     (lsu_misaligned),
    .lsu_timeout        (lsu_timeout),
    .cpu_datamem_addr   (cpu_datamem_addr),
    .cpu_datamem_wdata  (cpu_datamem_wdata),
    .cpu_datamem_bytesel(cpu_datamem_bytesel),
    .cpu_datamem_write  (cpu_datamem_write),
    .cpu_datamem_req    (cpu_datamem_req),
    .datamem_cpu_rdata  (datamem_cpu_rdata),
    .datamem_cpu_ack    (datamem_cpu_ack)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access. delay = number of ack-less WAIT cycles before ack; >= TMO means no ack.
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdat, input int delay);
    int          off;
    bit          ok;
    bit          timed_out;
    logic [3:0]  ebs;
    logic [31:0] ewd;
    logic [31:0] edata;
    logic [31:0] eaddr;
    off       = int'(a % 4);
    ok        = (sz == 2'd0) || (sz == 2'd1 && a % 2 == 0) || (sz == 2'd2 && off == 0);
    timed_out = (delay >= TMO);
    eaddr     = a - (a % 4);
    case (sz)
      2'd0:    begin ebs = 4'b0001 << off; ewd = (wd % 256) * 32'h01010101; end
      2'd1:    begin ebs = 4'b0011 << off; ewd = (wd % 65536) * 32'h00010001; end
      default: begin ebs = 4'b1111; ewd = wd; end
    endcase
    edata = rdat;
    if (sz == 2'd0) begin
      edata = (rdat >> (8 * off)) % 256;
      if (!uns && edata >= 128) edata = edata - 256;
    end else if (sz == 2'd1) begin
      edata = (rdat >> (8 * off)) % 65536;
      if (!uns && edata >= 32768) edata = edata - 65536;
    end

    exe_req_valid    = 1'b1;
    exe_req_write    = wr;
    exe_req_size     = sz;
    exe_req_unsigned = uns;
    exe_req_addr     = a;
    exe_req_wdata    = wd;
    exe_req_rd       = rd;
    #1;
    total++; if (lsu_stall !== ok) begin bad++; $display("FAIL stall_at_T: got %b want %b addr=%h size=%0d", lsu_stall, ok, a, sz); end
    next_cycle();

    if (!ok) begin
      total++; if (lsu_misaligned !== 1'b1) begin bad++; $display("FAIL misaligned_pulse: got %b want 1 addr=%h size=%0d", lsu_misaligned, a, sz); end
      total++; if (cpu_datamem_req !== 1'b0) begin bad++; $display("FAIL misaligned_no_req: got %b want 0", cpu_datamem_req); end
      total++; if (lsu_stall !== 1'b0) begin bad++; $display("FAIL misaligned_stall: got %b want 0", lsu_stall); end
      exe_req_valid = 1'b0;
      next_cycle();
      total++; if (lsu_misaligned !== 1'b0) begin bad++; $display("FAIL misaligned_one_cycle: got %b want 0", lsu_misaligned); end
      total++; if (cpu_datamem_req !== 1'b0) begin bad++; $display("FAIL misaligned_req_after: got %b want 0", cpu_datamem_req); end
      return;
    end

    for (int k = 0; k < TMO; k++) begin
      total++; if (cpu_datamem_req !== 1'b1) begin bad++; $display("FAIL wait_req k=%0d: got %b want 1", k, cpu_datamem_req); end
      total++; if (cpu_datamem_addr !== eaddr) begin bad++; $display("FAIL wait_addr k=%0d: got %h want %h", k, cpu_datamem_addr, eaddr); end
      total++; if (cpu_datamem_bytesel !== ebs) begin bad++; $display("FAIL wait_bytesel k=%0d: got %b want %b", k, cpu_datamem_bytesel, ebs); end
      total++; if (cpu_datamem_write !== wr) begin bad++; $display("FAIL wait_write k=%0d: got %b want %b", k, cpu_datamem_write, wr); end
      if (wr) begin
        total++; if (cpu_datamem_wdata !== ewd) begin bad++; $display("FAIL wait_wdata k=%0d: got %h want %h", k, cpu_datamem_wdata, ewd); end
      end
      total++; if (lsu_stall !== 1'b1) begin bad++; $display("FAIL wait_stall k=%0d: got %b want 1", k, lsu_stall); end
      total++; if (lsu_wb_valid !== 1'b0 || lsu_timeout !== 1'b0) begin bad++; $display("FAIL wait_no_pulse k=%0d: got wb=%b tmo=%b want 0 0", k, lsu_wb_valid, lsu_timeout); end
      datamem_cpu_ack   = (k == delay);
      datamem_cpu_rdata = (k == delay) ? rdat : $urandom;
      next_cycle();
      if (k == delay) break;
    end
    datamem_cpu_ack   = 1'b0;
    datamem_cpu_rdata = $urandom;

    total++; if (cpu_datamem_req !== 1'b0) begin bad++; $display("FAIL done_req: got %b want 0", cpu_datamem_req); end
    total++; if (lsu_stall !== 1'b0) begin bad++; $display("FAIL done_stall: got %b want 0", lsu_stall); end
    total++; if (lsu_timeout !== timed_out) begin bad++; $display("FAIL done_timeout: got %b want %b", lsu_timeout, timed_out); end
    total++; if (lsu_wb_valid !== (!wr && !timed_out)) begin bad++; $display("FAIL done_wb_valid: got %b want %b", lsu_wb_valid, (!wr && !timed_out)); end
    if (!wr && !timed_out) begin
      total++; if (lsu_wb_data !== edata) begin bad++; $display("FAIL wb_data: got %h want %h addr=%h size=%0d uns=%b", lsu_wb_data, edata, a, sz, uns); end
      total++; if (lsu_wb_rd !== rd) begin bad++; $display("FAIL wb_rd: got %0d want %0d", lsu_wb_rd, rd); end
    end
    exe_req_valid = 1'b0;
    next_cycle();
    total++; if (cpu_datamem_req !== 1'b0) begin bad++; $display("FAIL no_reaccept_req: got %b want 0", cpu_datamem_req); end
    total++; if (lsu_wb_valid !== 1'b0 || lsu_timeout !== 1'b0) begin bad++; $display("FAIL pulses_one_cycle: got wb=%b tmo=%b want 0 0", lsu_wb_valid, lsu_timeout); end
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    exe_req_valid     = 1'b0;
    exe_req_write     = 1'b0;
    exe_req_size      = 2'd0;
    exe_req_unsigned  = 1'b0;
    exe_req_addr      = 32'd0;
    exe_req_wdata     = 32'd0;
    exe_req_rd        = 5'd0;
    datamem_cpu_rdata = 32'd0;
    datamem_cpu_ack   = 1'b0;
    repeat (2) next_cycle();
    total++; if ({lsu_stall, lsu_wb_valid, lsu_misaligned, lsu_timeout, cpu_datamem_req, cpu_datamem_write} !== 6'd0)
      begin bad++; $display("FAIL reset_flags: got %b want 000000", {lsu_stall, lsu_wb_valid, lsu_misaligned, lsu_timeout, cpu_datamem_req, cpu_datamem_write}); end
    total++; if ({cpu_datamem_addr, cpu_datamem_wdata, lsu_wb_data} !== 96'd0 || cpu_datamem_bytesel !== 4'd0 || lsu_wb_rd !== 5'd0)
      begin bad++; $display("FAIL reset_buses: got addr=%h wdata=%h bs=%b wbd=%h rd=%0d want all 0", cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, lsu_wb_data, lsu_wb_rd); end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_word_load();
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 5'd3, 32'hDEADBEEF, 0);
  endtask

  task automatic test_byte_load();
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 5'd7, 32'h80A1_B2C3, 1);
    run_op(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 5'd8, 32'h80A1_B2C3, 2);
    run_op(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'd0, 5'd9, 32'h9ABC_1234, 0);
  endtask

  task automatic test_half_store();
    run_op(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234ABCD, 5'd0, 32'd0, 4);
    run_op(1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_005A, 5'd0, 32'd0, 0);
  endtask

  task automatic test_misaligned();
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 5'd1, 32'd0, 0);
    run_op(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'd0, 5'd1, 32'd0, 0);
    run_op(1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'hFFFF, 5'd1, 32'd0, 0);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 5'd4, 32'd0, TMO);
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'd0, 5'd5, 32'h1357_9BDF, TMO - 1);
  endtask

  task automatic test_ack_idle();
    datamem_cpu_ack = 1'b1;
    datamem_cpu_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      next_cycle();
      total++; if (lsu_wb_valid !== 1'b0 || cpu_datamem_req !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored: got wb=%b req=%b want 0 0", lsu_wb_valid, cpu_datamem_req); end
    end
    datamem_cpu_ack = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    exe_req_valid = 1'b1;
    exe_req_write = 1'b0;
    exe_req_size  = 2'd2;
    exe_req_addr  = 32'h0000_0300;
    exe_req_rd    = 5'd12;
    next_cycle();
    next_cycle();
    total++; if (cpu_datamem_req !== 1'b1) begin bad++; $display("FAIL pre_reset_req: got %b want 1", cpu_datamem_req); end
    rst_n = 1'b0;
    #1;
    total++; if (cpu_datamem_req !== 1'b0 || lsu_stall !== 1'b0) begin bad++; $display("FAIL reset_mid_wait: got req=%b stall=%b want 0 0", cpu_datamem_req, lsu_stall); end
    total++; if (cpu_datamem_addr !== 32'd0 || cpu_datamem_bytesel !== 4'd0 || lsu_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_wait_outs: got addr=%h bs=%b wb=%b want 0", cpu_datamem_addr, cpu_datamem_bytesel, lsu_wb_valid); end
    exe_req_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    datamem_cpu_ack = 1'b1;
    next_cycle();
    datamem_cpu_ack = 1'b0;
    total++; if (lsu_wb_valid !== 1'b0 || cpu_datamem_req !== 1'b0) begin bad++; $display("FAIL stale_after_reset: got wb=%b req=%b want 0 0", lsu_wb_valid, cpu_datamem_req); end
    next_cycle();
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 5'd13, 32'hCAFE_F00D, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    for (int i = 0; i < 60; i++) begin
      a    = $urandom;
      wd   = $urandom;
      rdat = $urandom;
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, wd, 5'($urandom_range(0, 31)), rdat, int'($urandom_range(0, 18)));
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 2'd2, 1'b0, 32'h0000_0500, 32'h0BAD_CAFE, 5'd0, 32'd0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'd0, 5'd0, 32'h0BAD_CAFE, 0);
    run_op(1'b0, 2'd1, 1'b1, 32'h0000_0502, 32'd0, 5'd31, 32'h8001_7FFF, 0);
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_ack_idle();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_lsu.md
Name: nanorv32_lsu

Overview:
Load/store unit between the nanorv32 execute stage and the data-memory port. It accepts one load/store per request from the execute stage and generates the word-aligned address, lane-replicated write data and byte selects. It runs the req/ack handshake with data memory and returns sign- or zero-extended load data for register write-back. It stalls the core while an access is outstanding and flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, WAIT cycles without ack before abort; 0 disables the timeout; legal range 0..65535 (16-bit counter).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
exe_req_valid  input  1  execute stage presents a load/store
exe_req_write  input  1  1=store, 0=load
exe_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
exe_req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
exe_req_addr  input  32  byte address
exe_req_wdata  input  32  store data (LSBs used for byte/half)
exe_req_rd  input  5  load destination register
lsu_stall  output  1  core must hold the current instruction
lsu_wb_valid  output  1  one-cycle pulse, load data valid
lsu_wb_rd  output  5  write-back register index
lsu_wb_data  output  32  extended load data
lsu_misaligned  output  1  one-cycle error pulse
lsu_timeout  output  1  one-cycle error pulse
cpu_datamem_addr  output  32  word-aligned address {addr[31:2],2'b00}
cpu_datamem_wdata  output  32  lane-replicated store data
cpu_datamem_bytesel  output  4  active byte lanes
cpu_datamem_write  output  1  1=write access
cpu_datamem_req  output  1  access request
datamem_cpu_rdata  input  32  read data
datamem_cpu_ack  input  1  access complete

Behaviour:
- Reset (asynchronous, immediate): state IDLE, done_r=0, timeout counter=0. All outputs 0, including cpu_datamem_req. Reset mid-WAIT drops req at once and discards the access.
- States are IDLE and WAIT. done_r is a one-cycle flag set in the cycle after any completion (load, store or timeout).
- Alignment: a half is misaligned when addr[0]=1. A word is misaligned when addr[1:0]!=0. size 11 is always misaligned.
- Accept: in IDLE with exe_req_valid=1, aligned and done_r=0 (cycle T):
  - Register addr, wdata lanes, bytesel, write, size, unsigned, rd, addr[1:0].
  - Enter WAIT; cpu_datamem_req=1 from T+1.
- Misaligned request in IDLE with done_r=0:
  - No memory access and no state change.
  - lsu_misaligned=1 at T+1 for one cycle; lsu_stall=0 at T.
- lsu_stall = (IDLE & exe_req_valid & aligned & ~done_r) | WAIT. This is combinational.
- done_r=1 retires the held request. The core is still presenting it, so stall is 0 and the request is not re-accepted.
- Lanes:
  - Byte: wdata={4{d[7:0]}}, bytesel=1<<addr[1:0].
  - Half: wdata={2{d[15:0]}}, bytesel=addr[1]?1100:0011.
  - Word: wdata=d, bytesel=1111.
  - Loads drive the same bytesel pattern.
- WAIT:
  - req, addr, wdata, bytesel and write are held stable until ack.
  - ack is sampled only in WAIT; ack outside WAIT is ignored. Ack in the first WAIT cycle (T+1) is legal.
- On ack at cycle A:
  - Return to IDLE; req=0 at A+1; done_r=1 at A+1.
  - Loads: lsu_wb_valid=1 at A+1 for one cycle, with lsu_wb_rd and lsu_wb_data.
  - Byte data: rdata[8*off+7:8*off]. Half data: rdata[16*addr[1]+15:16*addr[1]].
  - Extend to 32 bits: sign-extend unless unsigned. The unsigned bit is ignored for word loads.
  - Stores produce no wb_valid.
  - rd=0 loads still pulse wb_valid; the register file discards them.
- Timeout:
  - The counter clears on accept and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: req=0 next cycle, state IDLE, lsu_timeout=1 for one cycle, done_r=1, no wb.
  - Ack in the same cycle as the terminal count wins: normal completion.
- Minimum load latency: accept at T, wb at T+2.
- Outputs other than lsu_stall are registered.

Test Plan:
- Word load: addr 0x0000_0100, ack at T+1, rdata 0xDEADBEEF.
  -> req high only at T+1, addr 0x100, bytesel 1111; wb_valid at T+2 with data 0xDEADBEEF; stall 1 at T and T+1, 0 at T+2.
- Signed/unsigned byte load: addr 0x103, rdata 0x80xxxxxx.
  -> signed: wb_data 0xFFFFFF80, bytesel 1000.
  -> unsigned: wb_data 0x00000080.
- Half store: addr 0x102, wdata 0x1234ABCD, ack delayed 5 cycles.
  -> wdata 0xABCDABCD, bytesel 1100, write=1; req, addr and data stable for all 5 cycles; no wb_valid; stall drops the cycle after ack.
- Misaligned word load at 0x101 and size=11 request.
  -> lsu_misaligned pulse at T+1; cpu_datamem_req never asserted; stall 0.
- Timeout with TIMEOUT_CYCLES=16 and ack never asserted.
  -> req deasserts after 16 WAIT cycles; lsu_timeout one-cycle pulse; no wb_valid.
  -> Repeat with ack on the 16th cycle: normal completion, no timeout pulse.
- Async reset asserted mid-WAIT.
  -> req, stall and all outputs 0 immediately.
  -> After release, a new word load completes normally with no stale wb_valid.
